// File: rtl/icache_refill_controller_pkg.sv
// Shared types and helpers for the I-cache refill controller.
// Holds default cache geometry, the refill state encoding and address-split helpers.
// No logic of its own; imported by the controller and its line buffer.
package icache_refill_controller_pkg;

    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_SETS       = 64;

    typedef enum logic [2:0] {
        RS_IDLE  = 3'd0,
        RS_REQ   = 3'd1,
        RS_FILL  = 3'd2,
        RS_WRITE = 3'd3,
        RS_INV   = 3'd4
    } refill_state_t;

    // Number of byte-offset bits inside one cache line.
    function automatic int line_offset_bits(input int line_words, input int word_width);
        return $clog2(line_words * word_width / 8);
    endfunction

    // Bytes per cache line.
    function automatic int line_bytes(input int line_words, input int word_width);
        return line_words * word_width / 8;
    endfunction

endpackage

// File: rtl/icache_refill_controller_line_buffer.sv
// icache_line_buffer: assembles LINE_WORDS response beats into one cache line.
// Latency: beat stored on the clock it is valid; last_beat is combinational on the final beat.
// Backpressure: none; every valid beat is accepted. Ports: clk, rst (async low), start
// (re-arm counter), beat_vld/beat_dat in, line_dat/last_beat out.
module icache_line_buffer
    import icache_refill_controller_pkg::*;
#(
    parameter  int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter  int WORD_WIDTH = 32,
    localparam int CNT_W      = $clog2(LINE_WORDS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           beat_vld,
    input  logic [WORD_WIDTH-1:0]          beat_dat,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] line_dat,
    output logic                           last_beat
);

    logic [CNT_W-1:0]                cnt_q;
    logic [LINE_WORDS*WORD_WIDTH-1:0] line_q;

    // Counter wraps to 0 after the last beat because LINE_WORDS is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (beat_vld) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Line storage has no reset: its contents only matter once all beats have landed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (beat_vld && (cnt_q == CNT_W'(k))) begin
                line_q[k*WORD_WIDTH +: WORD_WIDTH] <= beat_dat;
            end
        end
    end

    assign line_dat  = line_q;
    assign last_beat = beat_vld && (cnt_q == CNT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/icache_refill_controller.sv
// icache_refill_controller: on a fetch miss, reads one line from memory and writes it into
// the I-cache; also sweeps every set invalid on request. Latency: miss->REQ 1 cycle, WRITE 1
// cycle after last beat, sweep SETS cycles. Backpressure: request held until memReqReady;
// response beats may have gaps. Ports: miss/flush/invalidate in, mem req/resp, fill/inv write port, stall/busy.
module icache_refill_controller
    import icache_refill_controller_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int WORD_WIDTH  = 32,
    parameter  int LINE_WORDS  = ICACHE_LINE_WORDS,
    parameter  int SETS        = ICACHE_SETS,
    localparam int OFFSET_BITS = line_offset_bits(LINE_WORDS, WORD_WIDTH),
    localparam int INDEX_BITS  = $clog2(SETS),
    localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS,
    localparam int LINE_BITS   = LINE_WORDS * WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  missValid,
    input  logic [ADDR_WIDTH-1:0] missAddr,
    input  logic                  flush,
    input  logic                  invalidateReq,
    output logic                  memReqValid,
    input  logic                  memReqReady,
    output logic [ADDR_WIDTH-1:0] memReqAddr,
    input  logic                  memRespValid,
    input  logic [WORD_WIDTH-1:0] memRespData,
    output logic                  fillWE,
    output logic [INDEX_BITS-1:0] fillIndex,
    output logic [TAG_BITS-1:0]   fillTag,
    output logic [LINE_BITS-1:0]  fillData,
    output logic                  invWE,
    output logic                  fetchStall,
    output logic                  busy,
    output logic                  invalidateDone
);

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
        ADDR_WIDTH'(line_bytes(LINE_WORDS, WORD_WIDTH) - 1);

    refill_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [INDEX_BITS-1:0] inv_idx_q;
    logic                  inv_pending_q;
    logic                  dropped_q;

    logic                  in_refill;
    logic                  inv_last;
    logic                  beat_vld;
    logic                  last_beat;
    logic                  buf_start;
    logic [LINE_BITS-1:0]  line_dat;

    assign in_refill = (state_q == RS_REQ) || (state_q == RS_FILL) || (state_q == RS_WRITE);
    assign inv_last  = (state_q == RS_INV) && (inv_idx_q == INDEX_BITS'(SETS - 1));
    // Beats outside FILL (stray after reset, or early in REQ) are dropped here.
    assign beat_vld  = (state_q == RS_FILL) && memRespValid;
    assign buf_start = (state_q == RS_REQ) && memReqReady;

    icache_line_buffer #(
        .LINE_WORDS (LINE_WORDS),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .start     (buf_start),
        .beat_vld  (beat_vld),
        .beat_dat  (memRespData),
        .line_dat  (line_dat),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RS_IDLE: begin
                // Invalidate wins over a same-cycle miss; fetch will re-present it.
                if (invalidateReq || inv_pending_q) begin
                    state_d = RS_INV;
                end else if (missValid) begin
                    state_d = RS_REQ;
                end
            end
            RS_REQ:   if (memReqReady) state_d = RS_FILL;
            RS_FILL:  if (last_beat)   state_d = RS_WRITE;
            RS_WRITE: state_d = (inv_pending_q || invalidateReq) ? RS_INV : RS_IDLE;
            RS_INV:   if (inv_last)    state_d = RS_IDLE;
            default:  state_d = RS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q        <= '0;
            inv_idx_q     <= '0;
            inv_pending_q <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            if ((state_q == RS_IDLE) && missValid && !invalidateReq && !inv_pending_q) begin
                addr_q <= missAddr;
            end

            // Held at 0 outside INV so every sweep starts from set 0.
            inv_idx_q <= (state_q == RS_INV) ? inv_idx_q + 1'b1 : '0;

            // Requests during INV are absorbed by the sweep already running.
            if (inv_last) begin
                inv_pending_q <= 1'b0;
            end else if (in_refill && invalidateReq) begin
                inv_pending_q <= 1'b1;
            end

            // A redirected fetch no longer waits on this line, but the line still lands.
            if (state_q == RS_WRITE) begin
                dropped_q <= 1'b0;
            end else if (in_refill && flush) begin
                dropped_q <= 1'b1;
            end
        end
    end

    assign memReqValid    = (state_q == RS_REQ);
    assign memReqAddr     = (state_q == RS_REQ) ? (addr_q & ~OFFSET_MASK) : '0;
    assign fillWE         = (state_q == RS_WRITE);
    assign invWE          = (state_q == RS_INV);
    assign fillIndex      = (state_q == RS_WRITE) ? addr_q[OFFSET_BITS +: INDEX_BITS] :
                            (state_q == RS_INV)   ? inv_idx_q : '0;
    assign fillTag        = (state_q == RS_WRITE) ? addr_q[ADDR_WIDTH-1 -: TAG_BITS] : '0;
    assign fillData       = (state_q == RS_WRITE) ? line_dat : '0;
    assign invalidateDone = inv_last;
    assign fetchStall     = (in_refill && (!dropped_q || missValid)) || (state_q == RS_INV);
    assign busy           = (state_q != RS_IDLE);

endmodule
